debounce_multi: RTL

- Parametrised N-channel successor to the single-button FSM debouncer. Each channel independently synchronises, debounces and edge-detects one raw input.
- Per channel it provides a stable level output and a configurable one-shot pulse: press, release, both, or press with auto-repeat.
- Sits between raw board inputs (buttons/switches) and the CPU I/O ports on the MCU clock. One instance replaces per-button debouncers.

---
 rtl/debounce_multi_if.sv | 14 +
 rtl/debounce_multi.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi_if.sv
// Signal bundle between debounce_multi and its consumer: raw inputs and mode in,
// debounced levels and event pulses out.
interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn;
    logic [1:0]      mode;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] db_pulse;
    logic            any_pulse;

    modport master (output btn, mode, input db_level, db_pulse, any_pulse);
    modport slave  (input btn, mode, output db_level, db_pulse, any_pulse);
endinterface

// File: rtl/debounce_multi.sv
// N-channel button debouncer: 2-FF synchroniser, per-channel debounce FSM,
// configurable one-shot pulse (press/release/both/auto-repeat) and a lagged OR.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 8,
    parameter int LOW_HIGH_CLKS = 100,
    parameter int HIGH_LOW_CLKS = 100,
    parameter int PULSE_CLKS    = 3,
    parameter int RPT_W         = 16,
    parameter int RPT_DELAY     = 1000,
    parameter int RPT_PERIOD    = 250
) (
    input  logic             i_clk,
    input  logic             i_rst,
    debounce_multi_if.slave  bus
);

    localparam int PC_W = (PULSE_CLKS > 1) ? $clog2(PULSE_CLKS) : 1;
    localparam logic [CNT_W-1:0] LH_LIMIT   = CNT_W'(LOW_HIGH_CLKS);
    localparam logic [CNT_W-1:0] HL_LIMIT   = CNT_W'(HIGH_LOW_CLKS);
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(RPT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_DELAY - RPT_PERIOD + 1);
    localparam logic [PC_W-1:0]  PC_LOAD    = PC_W'(PULSE_CLKS - 1);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("debounce_multi: N_CH out of range 1..32");
    end
    if (LOW_HIGH_CLKS < 1 || LOW_HIGH_CLKS > (2**CNT_W) - 1) begin : g_bad_lh
        $error("debounce_multi: LOW_HIGH_CLKS out of range");
    end
    if (HIGH_LOW_CLKS < 1 || HIGH_LOW_CLKS > (2**CNT_W) - 1) begin : g_bad_hl
        $error("debounce_multi: HIGH_LOW_CLKS out of range");
    end
    if (PULSE_CLKS < 1) begin : g_bad_pulse
        $error("debounce_multi: PULSE_CLKS must be >= 1");
    end
    if (RPT_DELAY < 1 || RPT_DELAY > (2**RPT_W) - 1 ||
        RPT_PERIOD < 1 || RPT_PERIOD > (2**RPT_W) - 1 ||
        RPT_PERIOD > RPT_DELAY + 1) begin : g_bad_rpt
        $error("debounce_multi: RPT_DELAY/RPT_PERIOD out of range");
    end

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_L2H  = 2'd1,
        ST_HIGH = 2'd2,
        ST_H2L  = 2'd3
    } state_t;

    logic [N_CH-1:0]  r_sync1;
    logic [N_CH-1:0]  r_sync2;
    state_t           r_state [N_CH];
    logic [CNT_W-1:0] r_cnt   [N_CH];
    logic [RPT_W-1:0] r_rc    [N_CH];
    logic [PC_W-1:0]  r_pc    [N_CH];
    logic [N_CH-1:0]  r_level;
    logic [N_CH-1:0]  r_pulse;
    logic             r_any;

    state_t           w_state_nx [N_CH];
    logic [CNT_W-1:0] w_cnt_nx   [N_CH];
    logic [RPT_W-1:0] w_rc_nx    [N_CH];
    logic [PC_W-1:0]  w_pc_nx    [N_CH];
    logic [N_CH-1:0]  w_level_nx;
    logic [N_CH-1:0]  w_pulse_nx;
    logic [N_CH-1:0]  w_press;
    logic [N_CH-1:0]  w_rel;
    logic [N_CH-1:0]  w_rpt;
    logic [N_CH-1:0]  w_qual;

    // Debounce FSM: cnt counts consecutive samples that disagree with the accepted level.
    always_comb begin
        w_level_nx = r_level;
        w_press    = '0;
        w_rel      = '0;
        w_rpt      = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = '0;
            w_rc_nx[i]    = '0;
            case (r_state[i])
                ST_LOW: begin
                    if (r_sync2[i]) begin
                        w_state_nx[i] = ST_L2H;
                        w_cnt_nx[i]   = CNT_W'(1);
                    end
                end
                ST_L2H: begin
                    if (!r_sync2[i]) begin
                        w_state_nx[i] = ST_LOW;
                    end else if (r_cnt[i] == LH_LIMIT) begin
                        w_state_nx[i] = ST_HIGH;
                        w_level_nx[i] = 1'b1;
                        w_press[i]    = 1'b1;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (r_rc[i] == RPT_FIRST) begin
                        w_rpt[i]   = 1'b1;
                        w_rc_nx[i] = RPT_RELOAD;
                    end else begin
                        w_rc_nx[i] = r_rc[i] + RPT_W'(1);
                    end
                    if (!r_sync2[i]) begin
                        w_state_nx[i] = ST_H2L;
                        w_cnt_nx[i]   = CNT_W'(1);
                        w_rc_nx[i]    = '0;
                    end
                end
                ST_H2L: begin
                    if (r_sync2[i]) begin
                        w_state_nx[i] = ST_HIGH;
                    end else if (r_cnt[i] == HL_LIMIT) begin
                        w_state_nx[i] = ST_LOW;
                        w_level_nx[i] = 1'b0;
                        w_rel[i]      = 1'b1;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx[i] = ST_LOW;
                end
            endcase
        end
    end

    // Pulse stretcher: a qualified event (re)loads the counter, so overlaps merge.
    always_comb begin
        w_qual     = (w_press & {N_CH{bus.mode != 2'b01}})
                   | (w_rel   & {N_CH{bus.mode == 2'b01 || bus.mode == 2'b10}})
                   | (w_rpt   & {N_CH{bus.mode == 2'b11}});
        w_pulse_nx = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_pc_nx[i] = '0;
            if (w_qual[i]) begin
                w_pulse_nx[i] = 1'b1;
                w_pc_nx[i]    = PC_LOAD;
            end else if (r_pc[i] != '0) begin
                w_pulse_nx[i] = 1'b1;
                w_pc_nx[i]    = r_pc[i] - PC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_pulse <= '0;
            r_any   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_LOW;
                r_cnt[i]   <= '0;
                r_rc[i]    <= '0;
                r_pc[i]    <= '0;
            end
        end else begin
            r_sync1 <= bus.btn;
            r_sync2 <= r_sync1;
            r_level <= w_level_nx;
            r_pulse <= w_pulse_nx;
            r_any   <= |r_pulse;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_rc[i]    <= w_rc_nx[i];
                r_pc[i]    <= w_pc_nx[i];
            end
        end
    end

    assign bus.db_level  = r_level;
    assign bus.db_pulse  = r_pulse;
    assign bus.any_pulse = r_any;

endmodule
